scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Frame-scan controller for the depth-mapping datapath. On a start pulse it walks a pixel coordinate pair (hcount, vcount) across an H_COUNT × V_COUNT frame. Each coordinate goes out on a valid/ready stream so downstream matching and memory stages can stall it. After the last pixel it waits a fixed pipeline-drain interval, then pulses frame-done. It replaces free-running event counters with a sequenced, stallable, abortable scan.

## Interface
- H_COUNT, 320, pixels per row; ≥2.
- V_COUNT, 240, rows per frame; ≥2.
- PIPE_LAT, 4, drain cycles after the final transfer before frame_done_out; 0 allowed.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n_in  input  1  synchronous, active-low reset.
- start_in  input  1  begin a frame scan; honoured only in IDLE.
- abort_in  input  1  cancel any scan; returns to IDLE next cycle.
- ready_in  input  1  downstream accepts the current coordinate.
- valid_out  output  1  hcount_out/vcount_out hold a valid coordinate.
- hcount_out  output  HW=max(1,$clog2(H_COUNT))  column, 0..H_COUNT-1.
- vcount_out  output  VW=max(1,$clog2(V_COUNT))  row, 0..V_COUNT-1.
- last_col_out  output  1  valid_out && hcount_out==H_COUNT-1.
- last_row_out  output  1  valid_out && vcount_out==V_COUNT-1.
- busy_out  output  1  high in SCAN, DRAIN, DONE.
- frame_done_out  output  1  one-cycle pulse on normal frame completion.

## Operation
- States: IDLE, SCAN, DRAIN, DONE (registered, one-hot or encoded).
- Reset (rst_n_in low at an edge): state IDLE; hcount, vcount and drain counter at 0. All outputs 0 the following cycle.
- IDLE: valid_out=0.
  - start_in && !abort_in: go to SCAN with hcount=vcount=0.
- SCAN: valid_out=1. Transfer means valid_out && ready_in.
  - No transfer: coordinates and valid_out held unchanged (stream stability rule).
  - Transfer, hcount<H_COUNT-1: hcount+1.
  - Transfer, hcount==H_COUNT-1, vcount<V_COUNT-1: hcount←0, vcount+1.
  - Transfer at (H_COUNT-1, V_COUNT-1): coordinates←0; go to DRAIN if PIPE_LAT>0, else DONE.
- DRAIN: valid_out=0. Drain counter counts 0..PIPE_LAT-1, one per cycle, then goes to DONE. Counter width is max(1,$clog2(PIPE_LAT+1)).
- DONE: frame_done_out=1 for exactly this cycle, then IDLE.
- abort_in in any state: IDLE next cycle, counters cleared, no frame_done_out. Abort beats start in the same cycle. Abort in DONE still lets that cycle's pulse stand.
- start_in outside IDLE is ignored, not queued.
- Counter arithmetic is compared against the parameter bounds, never left to natural wrap. Non-power-of-two sizes must wrap exactly at H_COUNT-1 / V_COUNT-1.

## Timing
- start_in sampled high in IDLE at cycle t: valid_out=1 with (0,0) at t+1.
- ready_in tied high: one transfer per cycle, H_COUNT·V_COUNT consecutive cycles. Final transfer at cycle T=t+H_COUNT·V_COUNT.
- valid_out low from T+1. DRAIN occupies T+1..T+PIPE_LAT. frame_done_out high at T+PIPE_LAT+1. IDLE (busy_out=0) at T+PIPE_LAT+2.
- Earliest next frame: start_in at T+PIPE_LAT+2 gives valid_out at T+PIPE_LAT+3.
- ready_in low for k cycles delays T by k. No coordinate is skipped or duplicated.
- All outputs are registered state or single-level decode of state; ready_in has no combinational path to valid_out.

## Test plan
- Params H=4, V=3, PIPE_LAT=2; reset; start_in at cycle 0 with ready_in=1:
  - valid_out cycles 1–12 with coordinates (0,0),(1,0)…(3,2) in raster order.
  - last_col_out at cycles 4, 8, 12; last_row_out at cycles 9–12.
  - frame_done_out only at cycle 15; busy_out low at 16.
- Backpressure: same setup, ready_in low on cycles 3–5 and 10. Coordinate (2,0) is held through cycles 3–5; total of 12 distinct transfers; frame_done_out at cycle 19.
- Abort mid-scan: abort_in at cycle 6. Cycle 7 has valid_out=0 and busy_out=0, and frame_done_out never fires. New start_in at cycle 8 gives (0,0) at cycle 9.
- Start/abort collisions:
  - start_in && abort_in together in IDLE: stays IDLE.
  - start_in pulses during SCAN and DRAIN: no effect on sequence or timing.
- PIPE_LAT=0, H=5, V=2: final transfer at cycle 10, frame_done_out at cycle 11.
- Reset mid-operation: rst_n_in low at cycle 7 for one cycle. Cycle 8 has all outputs 0 and hcount/vcount=0; the scan does not resume without start_in.

Source files
------------

// File: rtl/scan_sequencer.sv
// Frame-scan controller: walks (hcount, vcount) over an H_COUNT x V_COUNT frame on a
// valid/ready stream, drains the downstream pipeline, then pulses frame_done_out.
//
// state | meaning
// IDLE  | waiting for start_in; all outputs low
// SCAN  | presenting coordinates; advance on valid && ready
// DRAIN | waiting PIPE_LAT cycles for downstream stages to empty
// DONE  | single-cycle frame_done_out pulse
module scan_sequencer #(
    parameter int H_COUNT  = 320,
    parameter int V_COUNT  = 240,
    parameter int PIPE_LAT = 4,
    localparam int HW = (H_COUNT > 1) ? $clog2(H_COUNT) : 1,
    localparam int VW = (V_COUNT > 1) ? $clog2(V_COUNT) : 1,
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start_in,
    input  logic          abort_in,
    input  logic          ready_in,
    output logic          valid_out,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          last_col_out,
    output logic          last_row_out,
    output logic          busy_out,
    output logic          frame_done_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [HW-1:0] H_LAST     = HW'(H_COUNT - 1);
    localparam logic [HW-1:0] H_PEN      = HW'(H_COUNT - 2);
    localparam logic [VW-1:0] V_LAST     = VW'(V_COUNT - 1);
    localparam logic [VW-1:0] V_PEN      = VW'(V_COUNT - 2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t        state;
    logic [DW-1:0] drain_cnt;

    // Outputs are registered alongside the state so ready_in never reaches them combinationally.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || abort_in) begin
            state          <= IDLE;
            hcount_out     <= '0;
            vcount_out     <= '0;
            drain_cnt      <= '0;
            valid_out      <= 1'b0;
            last_col_out   <= 1'b0;
            last_row_out   <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state        <= SCAN;
                        hcount_out   <= '0;
                        vcount_out   <= '0;
                        valid_out    <= 1'b1;
                        busy_out     <= 1'b1;
                        last_col_out <= 1'b0;
                        last_row_out <= 1'b0;
                    end
                end
                SCAN: begin
                    if (ready_in) begin
                        if (hcount_out != H_LAST) begin
                            hcount_out   <= hcount_out + 1'b1;
                            last_col_out <= (hcount_out == H_PEN);
                        end else if (vcount_out != V_LAST) begin
                            hcount_out   <= '0;
                            vcount_out   <= vcount_out + 1'b1;
                            last_col_out <= 1'b0;
                            last_row_out <= (vcount_out == V_PEN);
                        end else begin
                            hcount_out   <= '0;
                            vcount_out   <= '0;
                            drain_cnt    <= '0;
                            valid_out    <= 1'b0;
                            last_col_out <= 1'b0;
                            last_row_out <= 1'b0;
                            if (PIPE_LAT > 0) begin
                                state <= DRAIN;
                            end else begin
                                state          <= DONE;
                                frame_done_out <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state          <= DONE;
                        drain_cnt      <= '0;
                        frame_done_out <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed frame tables, multi-cycle corner sequences and
// a randomized run against a pixel-index reference model.
module tb_scan_sequencer;

    localparam int AH = 4, AV = 3, AP = 2;
    localparam int BH = 5, BV = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;

    logic       a_valid, a_lc, a_lr, a_busy, a_done;
    logic [1:0] a_h, a_v;
    logic       b_valid, b_lc, b_lr, b_busy, b_done;
    logic [2:0] b_h;
    logic       b_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.H_COUNT(AH), .V_COUNT(AV), .PIPE_LAT(AP)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .abort_in(abort_a),
        .ready_in(ready_a), .valid_out(a_valid), .hcount_out(a_h), .vcount_out(a_v),
        .last_col_out(a_lc), .last_row_out(a_lr), .busy_out(a_busy),
        .frame_done_out(a_done)
    );

    scan_sequencer #(.H_COUNT(BH), .V_COUNT(BV), .PIPE_LAT(0)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .abort_in(abort_b),
        .ready_in(ready_b), .valid_out(b_valid), .hcount_out(b_h), .vcount_out(b_v),
        .last_col_out(b_lc), .last_row_out(b_lr), .busy_out(b_busy),
        .frame_done_out(b_done)
    );

    typedef struct {
        bit start;
        bit ready;
        bit valid;
        int h;
        int v;
        bit lc;
        bit lr;
        bit busy;
        bit done;
    } vec_t;

    vec_t tbl[17];

    // reference model: frame position as a flat pixel index
    int m_phase = 0;   // 0 idle, 1 scanning, 2 draining, 3 done pulse
    int m_pix   = 0;
    int m_left  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input int c, input bit valid, input int h,
                           input int v, input bit lc, input bit lr, input bit busy,
                           input bit done);
        chk({tag, ".valid"}, c, int'(a_valid), int'(valid));
        chk({tag, ".hcount"}, c, int'(a_h), h);
        chk({tag, ".vcount"}, c, int'(a_v), v);
        chk({tag, ".last_col"}, c, int'(a_lc), int'(lc));
        chk({tag, ".last_row"}, c, int'(a_lr), int'(lr));
        chk({tag, ".busy"}, c, int'(a_busy), int'(busy));
        chk({tag, ".frame_done"}, c, int'(a_done), int'(done));
    endtask

    task automatic model_step(input bit s, input bit ab, input bit rdy);
        if (ab) begin
            m_phase = 0;
            m_pix   = 0;
        end else begin
            case (m_phase)
                0: if (s) begin m_phase = 1; m_pix = 0; end
                1: if (rdy) begin
                    if (m_pix == AH * AV - 1) begin
                        m_pix   = 0;
                        m_phase = 2;
                        m_left  = AP;
                    end else begin
                        m_pix++;
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    initial begin
        int pix;
        bit vld;

        // nominal 4x3 frame, start at cycle 0, ready held high
        for (int c = 0; c < 17; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].ready = 1'b1;
            tbl[c].valid = (c >= 1 && c <= 12);
            tbl[c].h     = tbl[c].valid ? (c - 1) % AH : 0;
            tbl[c].v     = tbl[c].valid ? (c - 1) / AH : 0;
            tbl[c].lc    = (c == 4 || c == 8 || c == 12);
            tbl[c].lr    = (c >= 9 && c <= 12);
            tbl[c].busy  = (c >= 1 && c <= 15);
            tbl[c].done  = (c == 15);
        end

        step();
        step();
        rst_n = 1'b1;
        check_a("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_b.valid", 0, int'(b_valid), 0);
        chk("reset_b.busy", 0, int'(b_busy), 0);
        chk("reset_b.done", 0, int'(b_done), 0);

        for (int c = 0; c < 17; c++) begin
            start_a = tbl[c].start;
            ready_a = tbl[c].ready;
            check_a("frame", c, tbl[c].valid, tbl[c].h, tbl[c].v, tbl[c].lc, tbl[c].lr,
                    tbl[c].busy, tbl[c].done);
            step();
        end
        start_a = 1'b0;

        // backpressure: ready low on cycles 3-5 and 10
        pix = 0;
        for (int c = 0; c < 21; c++) begin
            start_a = (c == 0);
            ready_a = !((c >= 3 && c <= 5) || c == 10);
            vld = (c >= 1 && c <= 16);
            check_a("bp", c, vld, vld ? pix % AH : 0, vld ? pix / AH : 0,
                    vld && (pix % AH == AH - 1), vld && (pix / AH == AV - 1),
                    (c >= 1 && c <= 19), (c == 19));
            if (c >= 3 && c <= 5) begin
                chk("bp.hold_h", c, int'(a_h), 2);
                chk("bp.hold_v", c, int'(a_v), 0);
            end
            if (vld && ready_a) pix++;
            step();
        end
        chk("bp.transfers", 21, pix, AH * AV);

        // abort mid-scan at cycle 6, restart at cycle 8
        for (int c = 0; c < 11; c++) begin
            start_a = (c == 0 || c == 8);
            abort_a = (c == 6);
            ready_a = 1'b1;
            vld = (c >= 1 && c <= 6) || (c >= 9);
            pix = (c >= 9) ? c - 9 : c - 1;
            check_a("abort", c, vld, vld ? pix % AH : 0, vld ? pix / AH : 0,
                    vld && (pix % AH == AH - 1), 1'b0, vld, 1'b0);
            step();
        end
        abort_a = 1'b1;
        start_a = 1'b0;
        step();
        abort_a = 1'b0;

        // start together with abort in IDLE stays idle
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int c = 1; c < 3; c++) begin
            check_a("start_abort", c, 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        // stray start pulses in SCAN (5), DRAIN (13) and DONE (15) are ignored
        for (int c = 0; c < 17; c++) begin
            start_a = tbl[c].start || c == 5 || c == 13 || c == 15;
            ready_a = tbl[c].ready;
            check_a("stray_start", c, tbl[c].valid, tbl[c].h, tbl[c].v, tbl[c].lc,
                    tbl[c].lr, tbl[c].busy, tbl[c].done);
            step();
        end
        start_a = 1'b0;
        check_a("stray_start", 17, 0, 0, 0, 0, 0, 0, 0);

        // PIPE_LAT=0, 5x2: final transfer at 10, frame_done_out at 11
        for (int c = 0; c < 14; c++) begin
            start_b = (c == 0);
            ready_b = 1'b1;
            vld = (c >= 1 && c <= 10);
            pix = c - 1;
            chk("nolat.valid", c, int'(b_valid), int'(vld));
            chk("nolat.hcount", c, int'(b_h), vld ? pix % BH : 0);
            chk("nolat.vcount", c, int'(b_v), vld ? pix / BH : 0);
            chk("nolat.last_col", c, int'(b_lc), int'(c == 5 || c == 10));
            chk("nolat.last_row", c, int'(b_lr), int'(c >= 6 && c <= 10));
            chk("nolat.busy", c, int'(b_busy), int'(c >= 1 && c <= 11));
            chk("nolat.frame_done", c, int'(b_done), int'(c == 11));
            step();
        end
        start_b = 1'b0;

        // reset pulse during cycle 7 kills the scan; no resume without start
        for (int c = 0; c < 12; c++) begin
            start_a = (c == 0);
            ready_a = 1'b1;
            rst_n   = (c != 7);
            vld = (c >= 1 && c <= 7);
            pix = c - 1;
            check_a("reset_mid", c, vld, vld ? pix % AH : 0, vld ? pix / AH : 0,
                    vld && (pix % AH == AH - 1), 1'b0, vld, 1'b0);
            step();
        end
        rst_n = 1'b1;

        // randomized run against the pixel-index model
        m_phase = 0;
        m_pix   = 0;
        for (int c = 0; c < 4000; c++) begin
            start_a = ($urandom_range(0, 7) == 0);
            abort_a = ($urandom_range(0, 199) == 0);
            ready_a = ($urandom_range(0, 3) != 0);
            vld = (m_phase == 1);
            check_a("rand", c, vld, m_pix % AH, m_pix / AH,
                    vld && (m_pix % AH == AH - 1), vld && (m_pix / AH == AV - 1),
                    (m_phase != 0), (m_phase == 3));
            model_step(start_a, abort_a, ready_a);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
